// File: rtl/clk_div_pkg.sv
`default_nettype none
// ============================================================================
// Module  : clk_div_pkg
// Purpose : Shared types and constants for the clock-divider sequencer.
//           - state_t    : controller FSM states
//           - TC_W       : width of one divider stage (fixed at 4)
//           - DEFAULT_TC : terminal count loaded at reset (decade stage)
//           - tc_slice() : extract one stage's TC from a packed TC vector
// Revision: 1.0 - initial release
// ============================================================================
package clk_div_pkg;

  localparam int TC_W       = 4;
  // Upper bound on cascade depth; tc_slice() works on a vector padded to this.
  localparam int MAX_STAGES = 16;
  localparam logic [TC_W-1:0] DEFAULT_TC = 4'd9;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    RUN      = 2'd1,
    STOPPING = 2'd2
  } state_t;

  // Stage i occupies bits [4i+3:4i]; stage 0 is the fastest stage.
  function automatic logic [TC_W-1:0] tc_slice(
    input logic [MAX_STAGES*TC_W-1:0] vec,
    input int                         i
  );
    return vec[i*TC_W +: TC_W];
  endfunction

endpackage
`default_nettype wire

// File: rtl/clk_div_ctrl_div_stage.sv
`default_nettype none
// ============================================================================
// Module  : div_stage
// Purpose : One 4-bit modulo-(tc+1) counter of the divider cascade.
// Ports   : clk, rst   - clock, synchronous active-high reset
//           clr        - synchronous clear to 0 (period abort / stop)
//           en         - count enable (carry-in from the previous stage)
//           tc[3:0]    - terminal count; counter wraps after reaching it
//           count[3:0] - current count
//           at_tc      - count equals tc (combinational)
// Revision: 1.0 - initial release
// ============================================================================
module div_stage
  import clk_div_pkg::*;
(
  input  logic            clk,
  input  logic            rst,
  input  logic            clr,
  input  logic            en,
  input  logic [TC_W-1:0] tc,
  output logic [TC_W-1:0] count,
  output logic            at_tc
);

  logic [TC_W-1:0] r_count;

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      r_count <= '0;
    end else if (en) begin
      r_count <= (r_count == tc) ? '0 : r_count + 1'b1;
    end
  end

  assign count = r_count;
  assign at_tc = (r_count == tc);

endmodule
`default_nettype wire

// File: rtl/clk_div_ctrl.sv
`default_nettype none
// ============================================================================
// Module  : clk_div_ctrl
// Purpose : Sequencer for a cascade of 4-bit divider stages producing a
//           one-cycle tick once per prod(tc_i + 1) system clocks.
// Ports   : clk, rst   - clock, synchronous active-high reset
//           start/stop - run control (stop takes effect at period end)
//           cfg_valid/cfg_tc/cfg_ready - per-stage TC config handshake
//           stage_en   - per-stage count enables (carry chain)
//           count      - packed stage counts (same packing as cfg_tc)
//           tick       - one-cycle pulse per divided period
//           busy       - high in RUN and STOPPING
//           sq_out     - 50% duty square wave, toggles per tick
//                        (only when CLK_DIV_CTRL_SQUARE_EN is defined)
// Config  : CLK_DIV_CTRL_SQUARE_EN - adds the sq_out port and its flop.
// Note    : STAGES must not exceed clk_div_pkg::MAX_STAGES.
// Revision: 1.0 - initial release
// ============================================================================
module clk_div_ctrl
  import clk_div_pkg::*;
#(
  parameter int STAGES = 7
)(
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  input  logic                   stop,
  input  logic                   cfg_valid,
  input  logic [STAGES*TC_W-1:0] cfg_tc,
  output logic                   cfg_ready,
  output logic [STAGES-1:0]      stage_en,
  output logic [STAGES*TC_W-1:0] count,
  output logic                   tick,
  output logic                   busy
`ifdef CLK_DIV_CTRL_SQUARE_EN
  ,
  output logic                   sq_out
`endif
);

  localparam int PAD_W = MAX_STAGES * TC_W;

  state_t                   r_state;
  logic [STAGES*TC_W-1:0]   r_tc_act;
  logic [STAGES*TC_W-1:0]   r_tc_pend;
  logic                     r_pend_valid;
  logic                     r_tick;

  logic                     w_busy;
  logic                     w_cfg_fire;
  logic                     w_to_idle;
  logic                     w_wrap_all;
  logic [PAD_W-1:0]         w_tc_pad;

  assign w_busy     = (r_state == RUN) || (r_state == STOPPING);
  assign cfg_ready  = (r_state == IDLE) ? 1'b1 : !r_pend_valid;
  assign w_cfg_fire = cfg_valid && cfg_ready;
  // The tick cycle in STOPPING is the last busy cycle.
  assign w_to_idle  = (r_state == STOPPING) && r_tick;
  assign w_tc_pad   = PAD_W'(r_tc_act);

  // Each stage keeps its own enable wire so the carry chain is a plain
  // ripple of separate nets rather than a self-referencing vector.
  for (genvar gi = 0; gi < STAGES; gi++) begin : g_stage
    logic            w_en;
    logic            w_at_tc;
    if (gi == 0) begin : g_first
      assign w_en = w_busy;
    end else begin : g_chain
      assign w_en = g_stage[gi-1].w_en & g_stage[gi-1].w_at_tc;
    end

    div_stage u_stage (
      .clk   (clk),
      .rst   (rst),
      .clr   (w_to_idle),
      .en    (w_en),
      .tc    (tc_slice(w_tc_pad, gi)),
      .count (count[gi*TC_W +: TC_W]),
      .at_tc (w_at_tc)
    );

    assign stage_en[gi] = w_en;
  end

  assign w_wrap_all = g_stage[STAGES-1].w_en & g_stage[STAGES-1].w_at_tc;

`ifdef CLK_DIV_CTRL_SQUARE_EN
  logic r_sq;
  always_ff @(posedge clk) begin
    if (rst) begin
      r_sq <= 1'b0;
    end else if (w_wrap_all && !w_to_idle) begin
      r_sq <= !r_sq;
    end
  end
  assign sq_out = r_sq;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= IDLE;
      r_tc_act     <= {STAGES{DEFAULT_TC}};
      r_tc_pend    <= '0;
      r_pend_valid <= 1'b0;
      r_tick       <= 1'b0;
    end else begin
      // Suppress a wrap on the exit cycle so no tick leaks into IDLE
      // (only possible when the whole period is a single cycle).
      r_tick <= w_wrap_all && !w_to_idle;

      case (r_state)
        IDLE:     if (start && !stop) r_state <= RUN;
        RUN:      if (stop)           r_state <= STOPPING;
        STOPPING: if (r_tick)         r_state <= IDLE;
        default:                      r_state <= IDLE;
      endcase

      if (r_state == IDLE) begin
        if (w_cfg_fire) r_tc_act <= cfg_tc;
      end else if (w_to_idle) begin
        // Anything pending (including a value accepted right now) is
        // applied on the way into IDLE.
        if (w_cfg_fire)        r_tc_act <= cfg_tc;
        else if (r_pend_valid) r_tc_act <= r_tc_pend;
        r_pend_valid <= 1'b0;
      end else begin
        // Accept and apply never collide: cfg_ready is low while pending.
        if (w_wrap_all && r_pend_valid) begin
          r_tc_act     <= r_tc_pend;
          r_pend_valid <= 1'b0;
        end
        if (w_cfg_fire) begin
          r_tc_pend    <= cfg_tc;
          r_pend_valid <= 1'b1;
        end
      end
    end
  end

  assign tick = r_tick;
  assign busy = w_busy;

endmodule
`default_nettype wire
